// File: rtl/fsk_pkg.sv
// fsk_pkg: frame constants, state encoding and per-bit frame content shared by
// the FSK frame transmitter and its decoder.
package fsk_pkg;
   localparam logic [2:0] HEADER = 3'b111;
   localparam int HEADER_LEN = 3;
   localparam int DATA_W = 4;
   typedef enum logic [2:0] {S_IDLE, S_HEADER, S_DATA, S_PARITY, S_GAP} fsk_state_e;
   // Bit driven on the line for a given state and bit index; IDLE and GAP are 0.
   function automatic logic frame_bit(input fsk_state_e st, input logic [1:0] i,
                                      input logic [DATA_W-1:0] d);
      return st == S_HEADER ? HEADER[i] : st == S_DATA ? d[i] : st == S_PARITY ? ^d : 1'b0;
   endfunction
endpackage

// File: rtl/fsk_bit_timer.sv
// fsk_bit_timer: modulo-CLKS_PER_BIT counter marking the first and last clock of
// each serial bit, plus a one-cycle lookahead of the last clock.
module fsk_bit_timer #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic start_i,
   input  logic run_i,
   output logic bit_strobe_o,
   output logic bit_end_o,
   output logic pre_end_o
);
   localparam int CW = 8;
   logic [CW-1:0] cnt_q, cnt_d;
   assign bit_end_o    = cnt_q == CW'(CLKS_PER_BIT - 1);
   assign cnt_d        = start_i ? '0 : (run_i && !bit_end_o) ? cnt_q + CW'(1) : '0;
   assign pre_end_o    = cnt_d == CW'(CLKS_PER_BIT - 1);
   assign bit_strobe_o = run_i && cnt_q == '0;
   always_ff @(posedge clk) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
endmodule

// File: rtl/fsk_frame_tx.sv
// fsk_frame_tx: serialises a nibble as header, LSB-first data, even parity and
// an idle gap, with each bit held CLKS_PER_BIT clocks.
module fsk_frame_tx
   import fsk_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1,
   parameter int GAP_BITS     = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic              serial_out,
   output logic              bit_strobe,
   output logic              busy,
   output logic              frame_done
);
   localparam int IW = 8;
   fsk_state_e        state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d, len;
   logic [DATA_W-1:0] data_q, data_d;
   logic              busy_q, busy_d, ready_q, ready_d, serial_q, serial_d, done_q, done_d;
   logic              xfer, last, bit_end, pre_end;

   fsk_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk          (clk),
      .reset        (reset),
      .start_i      (xfer),
      .run_i        (busy_q),
      .bit_strobe_o (bit_strobe),
      .bit_end_o    (bit_end),
      .pre_end_o    (pre_end)
   );

   assign xfer = valid_in && ready_q;
   assign len  = state_q == S_HEADER ? IW'(HEADER_LEN) : state_q == S_DATA ? IW'(DATA_W) :
                 state_q == S_PARITY ? IW'(1) : IW'(GAP_BITS);
   assign last = idx_q == len - IW'(1);

   // Outputs are computed from next state so they are registered yet aligned with the bit.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      busy_d  = busy_q;
      if (xfer) begin
         state_d = S_HEADER;
         idx_d   = '0;
         data_d  = data_in;
         busy_d  = 1'b1;
      end else if (busy_q && bit_end) begin
         idx_d = last ? '0 : idx_q + IW'(1);
         if (last) begin
            case (state_q)
               S_HEADER: state_d = S_DATA;
               S_DATA:   state_d = S_PARITY;
               S_PARITY: state_d = S_GAP;
               default:  state_d = S_IDLE;
            endcase
            busy_d = state_q != S_GAP;
         end
      end
      serial_d = frame_bit(state_d, idx_d[1:0], data_d);
      ready_d  = state_d == S_IDLE;
      done_d   = state_d == S_GAP && idx_d == IW'(GAP_BITS - 1) && pre_end;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         data_q   <= '0;
         busy_q   <= 1'b0;
         ready_q  <= 1'b0;
         serial_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         ready_q  <= ready_d;
         serial_q <= serial_d;
         done_q   <= done_d;
      end
   end

   assign ready_out  = ready_q;
   assign serial_out = serial_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
endmodule

// File: tb/tb_fsk_frame_tx.sv
// tb_fsk_frame_tx: directed frames against hand-computed bit streams for
// CLKS_PER_BIT = 1 and 4, including back-to-back, mid-frame reset and input noise.
module tb_fsk_frame_tx;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] data_in = '0, d4 = '0;
   logic       valid_in = 1'b0, v4 = 1'b0;
   logic       ready_out, serial_out, bit_strobe, busy, frame_done;
   logic       r4, s4, bs4, busy4, fd4;
   int         n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   fsk_frame_tx #(.CLKS_PER_BIT(1), .GAP_BITS(3)) u_dut (
      .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .ready_out(ready_out), .serial_out(serial_out), .bit_strobe(bit_strobe),
      .busy(busy), .frame_done(frame_done));

   fsk_frame_tx #(.CLKS_PER_BIT(4), .GAP_BITS(3)) u_dut4 (
      .clk(clk), .reset(reset), .data_in(d4), .valid_in(v4),
      .ready_out(r4), .serial_out(s4), .bit_strobe(bs4),
      .busy(busy4), .frame_done(fd4));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference decoder: {wrong, nibble} from an 11-bit frame, first bit at MSB.
   function automatic logic [4:0] decode(input logic [10:0] b);
      return {^b[7:3], b[4], b[5], b[6], b[7]};
   endfunction

   task automatic run_frame1(input logic [3:0] d, input logic [10:0] exp, input string tag,
                             input bit noisy);
      logic [10:0] b;
      int st, dp, bz;
      b = '0; st = 0; dp = 0; bz = 0;
      @(negedge clk);
      data_in = d;
      valid_in = 1'b1;
      check({tag, "_rdy"}, ready_out, 1);
      @(negedge clk);
      valid_in = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         if (c > 1) @(negedge clk);
         b = {b[9:0], serial_out};
         st += int'(bit_strobe);
         bz += int'(busy);
         if (frame_done) dp = c;
         if (noisy) begin
            data_in  = ~data_in;
            valid_in = (c < 11) && (c % 2 == 1);
         end
      end
      check({tag, "_bits"}, b, exp);
      check({tag, "_dec"}, decode(b), {1'b0, d});
      check({tag, "_strb"}, st, 11);
      check({tag, "_busy"}, bz, 11);
      check({tag, "_done"}, dp, 11);
      @(negedge clk);
      check({tag, "_rdy_after"}, ready_out, 1);
      check({tag, "_idle"}, {busy, serial_out}, 0);
      @(negedge clk);
      check({tag, "_no_extra"}, busy, 0);
   endtask

   initial begin
      logic [22:0] s;
      int tx[2];
      int n, k, fd_cnt;
      logic [10:0] b;
      int st, dp, serr, herr;
      logic cur;

      repeat (3) @(negedge clk);
      check("rst_state", {serial_out, bit_strobe, busy, frame_done}, 0);
      check("rst_state4", {s4, bs4, busy4, fd4}, 0);
      reset = 1'b1;
      @(negedge clk);
      check("rst_ready", {ready_out, r4}, 2'b11);

      run_frame1(4'b1011, 11'b11111011000, "f1011", 1'b0);
      run_frame1(4'b0000, 11'b11100000000, "f0000", 1'b0);

      // valid held high across two frames
      s = '0; n = 0; k = 0; tx[0] = 0; tx[1] = 0;
      data_in = 4'b0110;
      valid_in = 1'b1;
      for (int i = 0; i < 80 && k < 23; i++) begin
         @(negedge clk);
         if (n > 0) begin s = {s[21:0], serial_out}; k++; end
         if (n == 1 && !ready_out) data_in = 4'b1111;
         if (n == 2 && !ready_out) valid_in = 1'b0;
         if (valid_in && ready_out && n < 2) begin tx[n] = i; n++; end
      end
      valid_in = 1'b0;
      check("b2b_count", n, 2);
      check("b2b_gap", tx[1] - tx[0], 12);
      check("b2b_bits", s, 23'b11101100000_0_11111110000);
      check("b2b_dec1", decode(s[22:12]), 5'b0_0110);
      check("b2b_dec2", decode(s[10:0]), 5'b0_1111);
      repeat (2) @(negedge clk);

      // reset during the third data bit
      data_in = 4'b0011;
      valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      repeat (5) @(negedge clk);
      check("rstmid_busy_pre", busy, 1);
      reset = 1'b0;
      @(negedge clk);
      check("rstmid_after", {serial_out, busy, frame_done}, 0);
      reset = 1'b1;
      fd_cnt = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (i == 0) check("rstmid_ready", ready_out, 1);
         fd_cnt += int'(frame_done) + int'(busy);
      end
      check("rstmid_no_done", fd_cnt, 0);
      run_frame1(4'b0101, 11'b11110100000, "f0101", 1'b0);

      run_frame1(4'b1100, 11'b11100110000, "noisy", 1'b1);

      // CLKS_PER_BIT = 4
      b = '0; st = 0; dp = 0; serr = 0; herr = 0; cur = 1'b0;
      @(negedge clk);
      check("c4_rdy", r4, 1);
      d4 = 4'b1001;
      v4 = 1'b1;
      @(negedge clk);
      v4 = 1'b0;
      d4 = 4'b0110;
      for (int c = 1; c <= 44; c++) begin
         if (c > 1) @(negedge clk);
         if ((c - 1) % 4 == 0) begin
            b = {b[9:0], s4};
            cur = s4;
            if (!bs4) serr++;
         end else begin
            if (s4 !== cur) herr++;
            if (bs4) serr++;
         end
         st += int'(bs4);
         if (fd4) dp = c;
      end
      check("c4_bits", b, 11'b11110010000);
      check("c4_strb", st, 11);
      check("c4_strb_pos", serr, 0);
      check("c4_hold", herr, 0);
      check("c4_done", dp, 44);
      @(negedge clk);
      check("c4_rdy_after", {r4, busy4}, 2'b10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
